// File: rtl/add_operand_feeder.sv
// Operand-pair FIFO feeding the lane-parallel adder; show-ahead head, one cycle push-to-valid when empty.
// Backpressure: in_ready drops only when full and never waits on out_ready; out_valid never looks at in_valid.
module add_operand_feeder #(
    parameter int LANES = 1,
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [32*LANES-1:0]     in_a,
    input  logic [32*LANES-1:0]     in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [32*LANES-1:0]     out_a,
    output logic [32*LANES-1:0]     out_b,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count,
    output logic [31:0]             beats
);
    localparam int W  = 32 * LANES;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_a [DEPTH];
    logic [W-1:0]  mem_b [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign in_ready  = !reset && (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_a     = out_valid ? mem_a[rd_ptr] : '0;
    assign out_b     = out_valid ? mem_b[rd_ptr] : '0;

    // Storage carries no reset; an empty FIFO masks its contents on the outputs.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            beats  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                beats  <= beats + 32'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_add_operand_feeder.sv
// Randomized and directed bench for add_operand_feeder against a queue-based reference model.
module tb_add_operand_feeder;
    localparam int LANES = 2;
    localparam int DEPTH = 4;
    localparam int W     = 32 * LANES;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_a;
    logic [W-1:0]  out_b;
    logic          flush = 1'b0;
    logic [2:0]    count;
    logic [31:0]   beats;

    add_operand_feeder #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .flush(flush), .count(count), .beats(beats)
    );

    always #5 clock = ~clock;

    typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; } pair_t;
    pair_t       q[$];
    int unsigned exp_beats = 0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [W-1:0] ea, eb;
        ea = (q.size() > 0) ? q[0].a : '0;
        eb = (q.size() > 0) ? q[0].b : '0;
        check("in_ready",  W'(in_ready),  W'(q.size() < DEPTH && !reset));
        check("out_valid", W'(out_valid), W'(q.size() > 0));
        check("count",     W'(count),     W'(q.size()));
        check("beats",     W'(beats),     W'(exp_beats));
        check("out_a",     out_a, ea);
        check("out_b",     out_b, eb);
    endtask

    // Apply one cycle of stimulus, advance the model by the handshake rules, then compare.
    task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ordy, input logic fl, output logic accepted);
        logic do_push, do_pop;
        pair_t p;
        in_valid = iv; in_a = a; in_b = b; out_ready = ordy; flush = fl;
        do_push = iv && (q.size() < DEPTH);
        do_pop  = ordy && (q.size() > 0);
        accepted = do_push && !fl;
        @(posedge clock);
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop) begin
                void'(q.pop_front());
                exp_beats++;
            end
            if (do_push) begin
                p.a = a; p.b = b;
                q.push_back(p);
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        logic          hold_v;
        logic [W-1:0]  hold_a, hold_b;
        int unsigned   b0;

        #12;
        check("rst_in_ready",  W'(in_ready),  '0);
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_out_a",     out_a, '0);
        reset = 1'b0;
        @(posedge clock); #1;
        check_all();

        // Single pair round trip
        step(1'b1, 64'h00000002_00000001, 64'h00000004_00000003, 1'b0, 1'b0, acc);
        check("single_head_a", out_a, 64'h00000002_00000001);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        check("single_beats", W'(beats), W'(1));

        // Fill to full; pair 5 is held until a slot opens
        for (int k = 1; k <= 5; k++)
            step(1'b1, W'(k), W'(k + 100), 1'b0, 1'b0, acc);
        check("full_count", W'(count), W'(4));
        check("full_in_ready", W'(in_ready), '0);
        step(1'b1, W'(5), W'(105), 1'b1, 1'b0, acc);
        check("full_pop_no_push", W'(acc), '0);
        step(1'b1, W'(5), W'(105), 1'b0, 1'b0, acc);
        check("pair5_accepted", W'(acc), W'(1));
        check("head_after_pop", out_a, W'(2));
        while (q.size() > 0) step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        // Continuous streaming wraps the pointers several times
        b0 = exp_beats;
        for (int k = 0; k < 20; k++)
            step(1'b1, W'(k), ~W'(k), 1'b1, 1'b0, acc);
        check("stream_beats", W'(beats - b0), W'(19));
        check("stream_count", W'(count), W'(1));
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        // Flush with simultaneous push and pop at count 3
        for (int k = 0; k < 3; k++)
            step(1'b1, W'(k + 200), W'(k + 300), 1'b0, 1'b0, acc);
        b0 = exp_beats;
        step(1'b1, W'(999), W'(999), 1'b1, 1'b1, acc);
        check("flush_count", W'(count), '0);
        check("flush_beats", W'(beats), W'(b0));
        step(1'b0, '0, '0, 1'b0, 1'b0, acc);

        // Random traffic; a producer holds its pair until accepted
        hold_v = 1'b0; hold_a = '0; hold_b = '0;
        for (int n = 0; n < 400; n++) begin
            logic fl;
            if (!hold_v) begin
                hold_v = ($urandom_range(0, 3) != 0);
                hold_a = {$urandom, $urandom};
                hold_b = {$urandom, $urandom};
            end
            fl = ($urandom_range(0, 31) == 0);
            step(hold_v, hold_a, hold_b, ($urandom_range(0, 2) != 0), fl, acc);
            if (acc || fl) hold_v = 1'b0;
        end
        step(1'b0, '0, '0, 1'b0, 1'b1, acc);

        // Asynchronous reset mid-stream at count 2
        step(1'b1, W'(11), W'(21), 1'b0, 1'b0, acc);
        step(1'b1, W'(12), W'(22), 1'b0, 1'b0, acc);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        q.delete();
        exp_beats = 0;
        check_all();
        #2 reset = 1'b0;
        @(posedge clock); #1;
        check_all();
        step(1'b1, 64'hDEADBEEF_CAFEF00D, 64'h01234567_89ABCDEF, 1'b0, 1'b0, acc);
        check("rt_a", out_a, 64'hDEADBEEF_CAFEF00D);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        check("rt_beats", W'(beats), W'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/add_operand_feeder.md
Name: add_operand_feeder

Overview:
- Upstream stage of the lane-parallel 32-bit adder.
- Buffers operand pairs (a, b) for all LANES in a DEPTH-entry FIFO.
- Presents the pairs to the adder over a valid/ready handshake.
- Exposes occupancy and a count of delivered pairs so simulation harnesses can pace stimulus and check throughput.

Parameters:
- LANES, 1, number of 32-bit lanes per operand bus.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer offers a pair.
- in_ready  output  1  feeder can accept a pair.
- in_a  input  32*LANES  operand A; lane i occupies bits [32*i+:32].
- in_b  input  32*LANES  operand B; same lane packing.
- out_valid  output  1  pair available to the adder.
- out_ready  input  1  adder consumes the pair.
- out_a  output  32*LANES  operand A at FIFO head.
- out_b  output  32*LANES  operand B at FIFO head.
- flush  input  1  synchronous discard of all entries.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- beats  output  32  number of pairs popped since reset.

Behaviour:
- Reset, asynchronous: clears read pointer, write pointer, count and beats to 0. While reset is high: in_ready=0, out_valid=0, out_a=out_b=0. Storage contents are don't-care.
- Reset mid-operation: all entries are lost. The first cycle after deassertion shows in_ready=1, count=0.
- Push: occurs when in_valid&&in_ready at a rising edge. Writes in_a/in_b at the write pointer, then increments the write pointer modulo DEPTH.
- Pop: occurs when out_valid&&out_ready at a rising edge. Increments the read pointer modulo DEPTH and increments beats; beats wraps 0xFFFFFFFF->0.
- in_ready: 1 iff count<DEPTH and not in reset. It does not depend on out_ready; there is no full-bypass.
- out_valid: 1 iff count>0. It does not depend on in_valid; there is no empty-bypass.
- out_a/out_b: show-ahead. Driven directly from the head entry, with no registered output stage. Forced to 0 when count==0.
- Latency: a pair pushed at edge N appears on out_* with out_valid=1 in the cycle after edge N, if the FIFO was empty.
- Producer handshake: in_valid/in_a/in_b must be held stable until accepted. The feeder does not check this.
- Consumer handshake: out_* stay stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged; both pointers advance.
- Full (count==DEPTH): in_ready=0, so an in_valid that cycle is not accepted. A pop in the same cycle takes effect, and in_ready rises the following cycle.
- Empty (count==0): out_valid=0, so out_ready is ignored and beats is unchanged.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap silently. count is maintained separately, so full and empty are unambiguous.
- Flush, synchronous: at the edge where flush=1, pointers and count go to 0. Any push or pop in that cycle is discarded and beats does not increment. The next cycle shows in_ready=1, out_valid=0.
- Lanes are independent data. No arithmetic is applied; bit patterns pass through unchanged.

Test Plan:
- Reset release, LANES=2, DEPTH=4:
  - One cycle after deassert -> in_ready=1, out_valid=0, count=0, beats=0, out_a=0.
- Single pair:
  - Push a={0x00000002,0x00000001}, b={0x00000004,0x00000003} with out_ready=0 -> next cycle out_valid=1, count=1, out_a/out_b equal the pushed values.
  - Then out_ready=1 for one cycle -> count=0, beats=1, out_a=0.
- Fill to full:
  - Push 5 pairs a=1..5 back-to-back with out_ready=0 -> first 4 accepted, count=4, in_ready=0. Pair 5 is held by the producer.
  - Pop once -> in_ready=1 the next cycle, pair 5 accepted, head a=2.
- Streaming:
  - in_valid=1 and out_ready=1 continuously for 20 cycles, a=k -> count stays 1 after the first push, pops in order 0..18, beats=19.
  - Pointers wrap 4+ times without loss.
- Flush with simultaneous push/pop at count=3 -> next cycle count=0, out_valid=0, beats unchanged, pushed pair absent.
- Reset mid-stream:
  - Assert reset asynchronously between edges at count=2 -> out_valid, in_ready and count drop to 0 immediately.
  - After release, beats=0 and a new pair round-trips correctly.
